// File: rtl/gpiotest_sequencer.sv
// GPIO bring-up pattern sequencer: walk, count, per-pin ID pulses, checkerboard.
// Build option GPIOTEST_AUTO_ADVANCE_EN adds an automatic mode advance.
module gpiotest_sequencer #(
  parameter int CLOCK_HZ   = 12_000_000,
  parameter int STEP_HZ    = 10,
  parameter int NUM_PINS   = 32,
  parameter int ID_GAP     = 4,
  parameter int AUTO_STEPS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                mode_next,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [1:0]          mode,
  output logic                step_tick
);

  localparam int DIV   = CLOCK_HZ / STEP_HZ;
  localparam int PW    = $clog2(DIV);
  localparam int FRAME = 2 * (NUM_PINS + ID_GAP);
  localparam int FW    = $clog2(FRAME);
  localparam logic [NUM_PINS-1:0] CHECKER =
    NUM_PINS'(32'h5555_5555);

  typedef enum logic [1:0] {
    WALK   = 2'd0,
    COUNT  = 2'd1,
    ID     = 2'd2,
    TOGGLE = 2'd3
  } mode_t;

  mode_t               mode_q, mode_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [FW-1:0]       ph_q, ph_d, ph_inc;
  logic [NUM_PINS-1:0] pat_d, id_pat;
  logic                tick_d;
  logic                term;
  logic                advance;
  logic                auto_next;

  assign term = enable && (pre_q == PW'(DIV - 1));

`ifdef GPIOTEST_AUTO_ADVANCE_EN
  localparam int AW = $clog2(AUTO_STEPS + 1);
  logic [AW-1:0] auto_q;

  assign auto_next = (auto_q == AW'(AUTO_STEPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       auto_q <= '0;
    else if (advance) auto_q <= '0;
    else if (term)    auto_q <= auto_q + AW'(1);
  end
`else
  assign auto_next = 1'b0;
`endif

  assign advance = mode_next | auto_next;

  assign ph_inc = (ph_q == FW'(FRAME - 1)) ? '0 : ph_q + FW'(1);

  // Pin i pulses on odd phases while (phase>>1) <= i: i+1 pulses/frame
  always_comb begin
    id_pat = '0;
    for (int i = 0; i < NUM_PINS; i++)
      id_pat[i] = ph_inc[0] && (int'(ph_inc >> 1) <= i);
  end

  always_comb begin
    mode_d = mode_q;
    pre_d  = pre_q;
    ph_d   = ph_q;
    pat_d  = gpio_out;
    tick_d = 1'b0;
    if (advance) begin
      mode_d = mode_t'(mode_q + 2'd1);
      pre_d  = '0;
      ph_d   = '0;
      pat_d  = '0;
    end else if (term) begin
      pre_d  = '0;
      tick_d = 1'b1;
      unique case (mode_q)
        WALK: pat_d = (gpio_out == '0) ? NUM_PINS'(1) :
          {gpio_out[NUM_PINS-2:0], gpio_out[NUM_PINS-1]};
        COUNT: pat_d = gpio_out + NUM_PINS'(1);
        ID: begin
          ph_d  = ph_inc;
          pat_d = id_pat;
        end
        TOGGLE: pat_d = (gpio_out == '0) ? CHECKER : ~gpio_out;
      endcase
    end else if (enable) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= WALK;
      pre_q     <= '0;
      ph_q      <= '0;
      gpio_out  <= '0;
      step_tick <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pre_q     <= pre_d;
      ph_q      <= ph_d;
      gpio_out  <= pat_d;
      step_tick <= tick_d;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_gpiotest_sequencer.sv
// Bench for gpiotest_sequencer: vector table over the four patterns,
// scoreboarded per step, plus freeze / terminal-count / reset corners.
module tb_gpiotest_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       mode_next = 1'b0;
  logic [7:0] gpio_out;
  logic [1:0] mode;
  logic       step_tick;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  gpiotest_sequencer #(
    .CLOCK_HZ(12), .STEP_HZ(3), .NUM_PINS(8),
    .ID_GAP(2), .AUTO_STEPS(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .mode_next(mode_next), .gpio_out(gpio_out),
    .mode(mode), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         presses;
    int         steps;
    logic [7:0] gpio;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pattern after step k (k>=1) of mode m
  function automatic logic [7:0] model(input logic [1:0] m,
                                       input int k);
    int ph;
    case (m)
      2'd0: return 8'(1 << ((k - 1) % 8));
      2'd1: return 8'(k % 256);
      2'd2: begin
        ph = k % 20;
        if (ph % 2 == 1) return 8'(8'hFF << (ph / 2));
        return 8'h00;
      end
      default: return (k % 2 == 1) ? 8'h55 : 8'hAA;
    endcase
  endfunction

  task automatic step_once(input logic [1:0] m, input int k);
    int n;
    logic [9:0] e;
    exp_q.push_back({m, model(m, k)});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_tick && n < 20);
    e = exp_q.pop_front();
    check($sformatf("step m%0d k%0d", m, k),
          {22'd0, mode, gpio_out}, {22'd0, e});
    check($sformatf("interval m%0d k%0d", m, k), n, 4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mode_next = 1'b0;
    enable = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_gpio", gpio_out, 0);
    check("rst_mode", mode, 0);
    check("rst_tick", step_tick, 0);
    rst_n = 1'b1;
  endtask

  task automatic press();
    mode_next = 1'b1;
    @(negedge clk);
    mode_next = 1'b0;
  endtask

  initial begin
    int bad;
    vecs[0]  = '{0, 1,   8'h01};
    vecs[1]  = '{0, 3,   8'h04};
    vecs[2]  = '{0, 8,   8'h80};
    vecs[3]  = '{0, 9,   8'h01};
    vecs[4]  = '{1, 255, 8'hFF};
    vecs[5]  = '{1, 256, 8'h00};
    vecs[6]  = '{1, 257, 8'h01};
    vecs[7]  = '{2, 1,   8'hFF};
    vecs[8]  = '{2, 15,  8'h80};
    vecs[9]  = '{2, 20,  8'h00};
    vecs[10] = '{3, 1,   8'h55};
    vecs[11] = '{3, 2,   8'hAA};
    vecs[12] = '{3, 3,   8'h55};

`ifndef GPIOTEST_AUTO_ADVANCE_EN
    foreach (vecs[v]) begin
      do_reset();
      for (int p = 0; p < vecs[v].presses; p++) press();
      check($sformatf("vec%0d_mode", v), mode, vecs[v].presses);
      check($sformatf("vec%0d_clr", v), gpio_out, 0);
      for (int k = 1; k <= vecs[v].steps; k++)
        step_once(2'(vecs[v].presses), k);
      check($sformatf("vec%0d_final", v), gpio_out, vecs[v].gpio);
    end

    // ID mode: second frame repeats the first
    do_reset();
    press();
    press();
    for (int k = 1; k <= 40; k++) step_once(2'd2, k);

    // Freeze mid-WALK at 0x04
    do_reset();
    for (int k = 1; k <= 3; k++) step_once(2'd0, k);
    enable = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_tick || gpio_out !== 8'h04) bad++;
    end
    check("freeze_bad_cycles", bad, 0);
    check("freeze_val", gpio_out, 8'h04);
    enable = 1'b1;
    step_once(2'd0, 4);

    // mode_next on the terminal-count cycle
    repeat (3) @(negedge clk);
    mode_next = 1'b1;
    @(negedge clk);
    mode_next = 1'b0;
    check("tc_tick", step_tick, 0);
    check("tc_mode", mode, 1);
    check("tc_gpio", gpio_out, 0);
    step_once(2'd1, 1);

    // Asynchronous reset mid-ID
    press();
    for (int k = 1; k <= 5; k++) step_once(2'd2, k);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gpio", gpio_out, 0);
    check("async_rst_mode", mode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_once(2'd0, 1);

    // Held mode_next advances once per cycle
    @(negedge clk);
    mode_next = 1'b1;
    repeat (3) @(negedge clk);
    mode_next = 1'b0;
    check("held_mode", mode, 3);
    check("held_gpio", gpio_out, 0);
    press();
    check("wrap_mode", mode, 0);
    check("wrap_gpio", gpio_out, 0);

    // No auto-advance: 40 steps stay in WALK
    do_reset();
    for (int k = 1; k <= 40; k++) step_once(2'd0, k);
    check("noauto_mode", mode, 0);
`else
    do_reset();
    for (int k = 1; k <= 10; k++) step_once(2'd0, k);
    @(negedge clk);
    check("auto_mode1", mode, 1);
    check("auto_clr", gpio_out, 0);
    for (int m = 1; m < 4; m++) begin
      for (int k = 1; k <= 10; k++) step_once(2'(m), k);
      @(negedge clk);
      check($sformatf("auto_mode_after%0d", m), mode, 2'(m + 1));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
